// File: rtl/ring_dma_reader.sv
// Ring-buffer DMA reader: streams a job of flits from the PDU ring to the host path in bursts.
// Optional RING_DMA_STATS_EN builds the job/flit statistics counters.
module ring_dma_reader #(
  parameter int unsigned PDU_DEPTH  = 512,
  parameter int unsigned PDU_AWIDTH = $clog2(PDU_DEPTH),
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_start,
  input  logic [PDU_AWIDTH-1:0] dma_base_addr,
  input  logic [PDU_AWIDTH-1:0] dma_size,
  output logic                  dma_done,
  output logic                  busy,
  output logic [PDU_AWIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic                  rd_valid,
  input  logic [511:0]          rd_data,
  output logic [511:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [31:0]           stat_jobs,
  output logic [31:0]           stat_flits
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW  = FAW + 2;
  localparam logic [PDU_AWIDTH-1:0] BURST_LAST = PDU_AWIDTH'(MAX_BURST - 1);
  localparam logic [PDU_AWIDTH-1:0] ONE        = PDU_AWIDTH'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   zero_hold;
  logic [PDU_AWIDTH-1:0]  reads_left, out_left, burst_left;
  logic [1:0]             outstanding;
  logic                   sop_flag;
  logic [511:0]           mem [FIFO_DEPTH];
  logic [FAW:0]           wr_ptr, rd_ptr, fifo_count;
  logic [SW-1:0]          occ;
  logic                   start, fifo_wr, pop, last_pop;

  always_comb begin
    start      = (state == IDLE) && dma_start;
    fifo_count = wr_ptr - rd_ptr;
    out_valid  = (fifo_count != '0);
    pop        = out_valid && out_ready;
    last_pop   = pop && (out_left == ONE);
    // returns for reads abandoned by a reset are dropped
    fifo_wr    = rd_valid && (outstanding != 2'd0);
    occ        = SW'(outstanding) + SW'(fifo_count);
    rd_en      = (state == READ) && (reads_left != '0) && (occ < SW'(FIFO_DEPTH));
    out_data   = out_valid ? mem[rd_ptr[FAW-1:0]] : '0;
    out_sop    = out_valid && sop_flag;
    out_eop    = out_valid && ((burst_left == '0) || (out_left == ONE));
    // a zero-length job waits one extra cycle in DONE before pulsing
    dma_done   = (state == DONE) && !zero_hold;
    busy       = (state != IDLE) && !dma_done;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (dma_start) state_nxt = (dma_size == '0) ? DONE : READ;
      READ:  if (rd_en && (reads_left == ONE)) state_nxt = DRAIN;
      DRAIN: if (last_pop) state_nxt = DONE;
      DONE:  if (!zero_hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      zero_hold   <= 1'b0;
      rd_addr     <= '0;
      reads_left  <= '0;
      out_left    <= '0;
      burst_left  <= '0;
      sop_flag    <= 1'b0;
      outstanding <= 2'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state     <= state_nxt;
      zero_hold <= start && (dma_size == '0);
      if (start) begin
        rd_addr    <= dma_base_addr;
        reads_left <= dma_size;
      end else if (rd_en) begin
        rd_addr    <= rd_addr + ONE;
        reads_left <= reads_left - ONE;
      end
      if (start) begin
        out_left   <= dma_size;
        burst_left <= BURST_LAST;
        sop_flag   <= 1'b1;
      end else if (pop) begin
        out_left   <= out_left - ONE;
        burst_left <= (burst_left == '0) ? BURST_LAST : burst_left - ONE;
        sop_flag   <= (burst_left == '0);
      end
      case ({rd_en, fifo_wr})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr[FAW-1:0]] <= rd_data;
  end

`ifdef RING_DMA_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_jobs  <= '0;
      stat_flits <= '0;
    end else begin
      if (dma_done) stat_jobs  <= stat_jobs + 32'd1;
      if (pop)      stat_flits <= stat_flits + 32'd1;
    end
  end
`else
  assign stat_jobs  = '0;
  assign stat_flits = '0;
`endif

endmodule

// File: tb/tb_ring_dma_reader.sv
// Directed self-checking bench for ring_dma_reader with a two-cycle-latency ring memory model.
module tb_ring_dma_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dma_start = 1'b0;
  logic [8:0]   dma_base_addr = '0;
  logic [8:0]   dma_size = '0;
  logic         dma_done, busy, rd_en, rd_valid, out_valid, out_sop, out_eop;
  logic         out_ready = 1'b0;
  logic [8:0]   rd_addr;
  logic [511:0] rd_data, out_data;
  logic [31:0]  stat_jobs, stat_flits;

  int unsigned nchecks = 0;
  int unsigned nerr = 0;
  int unsigned exp_jobs = 0;
  int unsigned exp_flits = 0;

`ifdef RING_DMA_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  ring_dma_reader #(
    .PDU_DEPTH (512),
    .MAX_BURST (16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dma_start    (dma_start),
    .dma_base_addr(dma_base_addr),
    .dma_size     (dma_size),
    .dma_done     (dma_done),
    .busy         (busy),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .stat_jobs    (stat_jobs),
    .stat_flits   (stat_flits)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] data_of(input logic [8:0] a);
    return {16{23'h2B3C1D, a}};
  endfunction

  // ring memory: data appears exactly two cycles after the read strobe
  logic       v1, v2;
  logic [8:0] a1, a2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      v1 <= rd_en; a1 <= rd_addr;
      v2 <= v1;    a2 <= a1;
    end
  end
  assign rd_valid = v2;
  assign rd_data  = v2 ? data_of(a2) : '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_jobs"},  stat_jobs,  STATS ? exp_jobs  : 0);
    chk({tag, "_flits"}, stat_flits, STATS ? exp_flits : 0);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready ~30% duty
  task automatic run_job(input int unsigned base, input int unsigned size,
                         input int unsigned mode, input bit restart);
    int unsigned cyc, nrd, nacc, first_v, last_acc, done_cyc;
    bit got_done, stall, hs;
    logic [511:0] pd;
    logic ps, pe;
    @(negedge clk);
    dma_start = 1'b1; dma_base_addr = base[8:0]; dma_size = size[8:0];
    out_ready = (mode == 0);
    @(negedge clk);
    dma_start = 1'b0;
    chk("busy_t1", busy, 1);
    chk("rd_en_t1", rd_en, 1);
    cyc = 1; nrd = 0; nacc = 0; first_v = 0; last_acc = 0; done_cyc = 0;
    got_done = 0; stall = 0; pd = '0; ps = 0; pe = 0;
    while (!got_done && cyc < 2000) begin
      if (restart && cyc == 2) begin
        dma_start = 1'b1; dma_base_addr = 9'd300; dma_size = 9'd7;
      end else begin
        dma_start = 1'b0;
      end
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_sop", out_sop, ps);
        chk("hold_eop", out_eop, pe);
      end
      chk("occupancy_le_8", ((rd_en ? nrd + 1 : nrd) - nacc) <= 8, 1);
      if (rd_en) begin
        chk("rd_addr", rd_addr, (base + nrd) % 512);
        nrd++;
      end
      if (out_valid && first_v == 0) begin
        first_v = cyc;
        if (mode == 0) chk("first_valid_cycle", cyc, 4);
      end
      if (dma_done) begin
        got_done = 1; done_cyc = cyc;
        chk("done_flits", nacc, size);
        chk("done_busy", busy, 0);
        chk("done_latency", done_cyc, last_acc + 1);
      end
      hs = out_valid && out_ready;
      if (hs) begin
        chk("out_data", out_data, data_of(9'((base + nacc) % 512)));
        chk("out_sop", out_sop, (nacc % 16) == 0);
        chk("out_eop", out_eop, ((nacc % 16) == 15) || (nacc == size - 1));
        nacc++; last_acc = cyc;
      end
      stall = out_valid && !out_ready;
      pd = out_data; ps = out_sop; pe = out_eop;
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    dma_start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("reads_issued", nrd, size);
    if (mode == 0) chk("throughput", last_acc - first_v, size - 1);
    exp_jobs++;
    exp_flits += size;
    @(negedge clk);
    chk("done_single", dma_done, 0);
    chk("idle_busy", busy, 0);
    chk_stats("stats");
  endtask

  initial begin
    int unsigned nacc, guard;
    #1;
    chk("rst_done", dma_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk_stats("rst_stats");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(0, 5, 0, 0);
    run_job(10, 40, 0, 0);
    run_job(510, 4, 0, 0);
    run_job(7, 20, 1, 0);

    // zero-length job
    @(negedge clk);
    dma_start = 1'b1; dma_base_addr = 9'd33; dma_size = 9'd0;
    @(negedge clk);
    dma_start = 1'b0;
    chk("zero_t1_done", dma_done, 0);
    chk("zero_t1_rd_en", rd_en, 0);
    @(negedge clk);
    chk("zero_t2_done", dma_done, 1);
    chk("zero_t2_rd_en", rd_en, 0);
    chk("zero_t2_valid", out_valid, 0);
    exp_jobs++;
    @(negedge clk);
    chk("zero_t3_done", dma_done, 0);
    chk("zero_t3_valid", out_valid, 0);
    chk_stats("zero_stats");

    run_job(200, 8, 0, 1);

    // reset while flit 3 of 10 is presented
    @(negedge clk);
    dma_start = 1'b1; dma_base_addr = 9'd50; dma_size = 9'd10; out_ready = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    nacc = 0; guard = 0;
    while (!(out_valid && nacc == 3) && guard < 100) begin
      if (out_valid && out_ready) nacc++;
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_reached", nacc, 3);
    chk("rst_mid_data", out_data, data_of(9'd53));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data0", out_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_rd_addr", rd_addr, 0);
    chk("rst_mid_sop", out_sop, 0);
    chk("rst_mid_eop", out_eop, 0);
    chk("rst_mid_done", dma_done, 0);
    exp_jobs = 0; exp_flits = 0;
    chk_stats("rst_mid_stats");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    run_job(100, 3, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/ring_dma_reader.md
# ring_dma_reader

DMA-side consumer of the PDU ring buffer. Accepts a job (`dma_start`, `dma_base_addr`, `dma_size`) from the buffer. Reads that many 512-bit flits through the buffer's fixed two-cycle read port and streams them to the host-write path on a ready/valid interface, split into bursts. Signals `dma_done` once the last flit has been accepted downstream.

## Interface
- `PDU_DEPTH`, 512, ring buffer depth in flits; power of two.
- `PDU_AWIDTH`, $clog2(PDU_DEPTH), flit address/size width.
- `MAX_BURST`, 16, max flits per output burst; 1..PDU_DEPTH.
- `FIFO_DEPTH`, 8, output skid FIFO depth in flits; ≥ 4, power of two.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `dma_start`  in  1  one-cycle job request.
- `dma_base_addr`  in  PDU_AWIDTH  first flit address of job.
- `dma_size`  in  PDU_AWIDTH  job length in flits.
- `dma_done`  out  1  one-cycle job completion pulse.
- `busy`  out  1  high from job acceptance until `dma_done`.
- `rd_addr`  out  PDU_AWIDTH  ring buffer read address.
- `rd_en`  out  1  ring buffer read strobe.
- `rd_valid`  in  1  read data valid, exactly 2 cycles after `rd_en`.
- `rd_data`  in  512  read data.
- `out_data`  out  512  flit to host path.
- `out_valid`  out  1  flit valid.
- `out_ready`  in  1  downstream accept.
- `out_sop`  out  1  first flit of burst.
- `out_eop`  out  1  last flit of burst.
- `stat_jobs`  out  32  completed jobs.
- `stat_flits`  out  32  flits accepted downstream.

## Operation
- FSM states:
  - IDLE: on `dma_start`, latch base/size, go to READ. If size = 0, go to DONE instead.
  - READ: issue reads. After the last `rd_en`, go to DRAIN.
  - DRAIN: when the last flit is accepted (`out_valid & out_ready`), go to DONE.
  - DONE: pulse `dma_done`, return to IDLE.
- `dma_start` outside IDLE is ignored. The job is not queued, and no other state changes.
- Read issue: `rd_en` asserts in READ only when `outstanding + fifo_count < FIFO_DEPTH`.
  - `outstanding` = reads issued whose `rd_valid` has not yet returned; 0..2.
  - Issued data therefore always has a FIFO slot, and `rd_valid` is never dropped.
- `rd_addr` starts at the latched base and increments by 1 per issued read, modulo PDU_DEPTH (natural PDU_AWIDTH wrap).
- Remaining-read count and remaining-burst count are PDU_AWIDTH-bit down-counters.
- FIFO: written on `rd_valid`; head drives `out_data`; popped on `out_valid & out_ready`.
- Framing is tracked at the FIFO output:
  - `out_sop` on the first flit of the job and on every flit following a burst end.
  - `out_eop` on every MAX_BURST-th flit of the job and on the final flit.
  - A job of N flits yields ceil(N/MAX_BURST) bursts.
- `out_valid` never drops without a handshake. `out_data`, `out_sop` and `out_eop` are stable while `out_valid & !out_ready`.

## Timing
- Reset (async assert, sync deassert by the system) forces the following. Reset mid-job abandons the job with no `dma_done`.
  - State IDLE, FIFO empty.
  - `dma_done`, `busy`, `rd_en`, `out_valid`, `out_sop`, `out_eop` = 0.
  - `rd_addr`, `out_data`, `stat_*` = 0.
- With `dma_start` sampled at cycle T (size ≥ 1):
  - `busy` = 1 from T+1.
  - First `rd_en` at T+1.
  - `rd_valid` returns at T+3.
  - `out_valid` no earlier than T+4.
- With `out_ready` held high, throughput is 1 flit/cycle sustained.
- Last flit accepted at cycle L: `dma_done` = 1 at L+1, `busy` = 0 at L+1.
  - A new `dma_start` is accepted from L+2.
- Size = 0 at T: `dma_done` at T+2, no `rd_en`, no output.

## Configuration
- `RING_DMA_STATS_EN`:
  - Defined: `stat_jobs` increments with each `dma_done`; `stat_flits` increments on each output handshake. Both counters wrap at 2^32 and reset to 0.
  - Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- base=0, size=5, `out_ready`=1 → `rd_addr` 0..4 on T+1..T+5. Five flits carrying data matching addresses 0..4. `sop` on flit 0, `eop` on flit 4. `dma_done` one cycle after flit 4.
- base=10, size=40, MAX_BURST=16 → bursts of 16/16/8. `sop` on flits 0, 16, 32; `eop` on flits 15, 31, 39.
- base=PDU_DEPTH-2, size=4 → `rd_addr` sequence 510, 511, 0, 1 (PDU_DEPTH=512); data order preserved.
- size=20, `out_ready` random 30% duty → no flit lost or duplicated. Reads outstanding + FIFO never exceed 8. Outputs hold while stalled.
- size=0 → `dma_done` at T+2 with no `rd_en`. A second `dma_start` mid-job is ignored: one `dma_done` only, `stat_jobs` +1 (with `RING_DMA_STATS_EN`).
- `rst_n` low mid-job (flit 3 of 10) → all outputs 0 immediately. A subsequent job runs cleanly from a fresh base.
